// File: rtl/fraise_infer_seq.sv
// Inference sequencer for the stochastic-log array: seeds the array, walks the
// observation addresses, then counts bit_out per matrix line over N samples.

module fraise_lane_cnt #(
    parameter int CntWidth = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                en,
    output logic [CntWidth-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (en && count != {CntWidth{1'b1}})
            count <= count + 1'b1;
    end
endmodule

module fraise_infer_seq #(
    parameter int MatrixSize   = 4,
    parameter int ArraySize    = 64,
    parameter int Nword_used   = 3,
    parameter int CntWidth     = 8,
    parameter int ArrayLatency = 1,
    localparam int ArraySizeLog2  = (ArraySize > 2) ? $clog2(ArraySize) : 1,
    localparam int MatrixSizeLog2 = (MatrixSize > 2) ? $clog2(MatrixSize) : 1,
    localparam int ObsWidth       = ArraySizeLog2 + 3,
    localparam int AddrWidth      = ArraySizeLog2 + MatrixSizeLog2,
    localparam int SeedWidth      = 2 ** Nword_used
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [CntWidth-1:0]            nsamples_i,
    input  logic [SeedWidth-1:0]           seed_i,
    input  logic [MatrixSize*ObsWidth-1:0] obs_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           load_seed_o,
    output logic [SeedWidth-1:0]           seeds_o,
    output logic                           inference_o,
    output logic [AddrWidth-1:0]           addr_col_o,
    output logic [AddrWidth-1:0]           addr_row_o,
    input  logic [MatrixSize-1:0]          bit_out_i,
    output logic [MatrixSize*CntWidth-1:0] result_o,
    output logic                           result_valid_o
);
    typedef enum logic [2:0] {IDLE, LOAD_SEED, ADDR, SAMPLE, DRAIN, DONE} state_t;

    state_t                          state;
    logic [MatrixSizeLog2-1:0]       line;
    logic [CntWidth-1:0]             scnt;
    logic [1:0]                      dcnt;
    logic [MatrixSize*ObsWidth-1:0]  obs_q;
    logic [CntWidth-1:0]             nsamp_q;
    logic [ArrayLatency-1:0]         vld_pipe;
    logic                            accept;
    logic                            acc_en;
    logic [MatrixSizeLog2-1:0]       nline;

    assign accept = (state == IDLE) && start_i && !abort_i;
    assign acc_en = vld_pipe[ArrayLatency-1];
    assign nline  = line + 1'b1;

    function automatic logic [ObsWidth-1:0] lane_obs(input logic [MatrixSizeLog2-1:0] k);
        return obs_q[32'(k)*ObsWidth +: ObsWidth];
    endfunction

    function automatic logic [AddrWidth-1:0] col_of(input logic [MatrixSizeLog2-1:0] k);
        logic [ObsWidth-1:0] o;
        o = lane_obs(k);
        return (AddrWidth'(k) << ArraySizeLog2) | (AddrWidth'(o[2:0]) << (ArraySizeLog2 - 3));
    endfunction

    function automatic logic [AddrWidth-1:0] row_of(input logic [MatrixSizeLog2-1:0] k);
        logic [ObsWidth-1:0] o;
        o = lane_obs(k);
        return AddrWidth'(o[ObsWidth-1:3]);
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= IDLE;
            line           <= '0;
            scnt           <= '0;
            dcnt           <= '0;
            obs_q          <= '0;
            nsamp_q        <= '0;
            vld_pipe       <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            load_seed_o    <= 1'b0;
            seeds_o        <= '0;
            inference_o    <= 1'b0;
            addr_col_o     <= '0;
            addr_row_o     <= '0;
            result_valid_o <= 1'b0;
        end else if (abort_i && state != IDLE) begin
            // Counters are left alone so a partial run can still be inspected.
            state       <= IDLE;
            vld_pipe    <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            load_seed_o <= 1'b0;
            inference_o <= 1'b0;
        end else begin
            load_seed_o <= 1'b0;
            inference_o <= 1'b0;
            done_o      <= 1'b0;
            vld_pipe    <= (vld_pipe << 1) | ArrayLatency'(state == SAMPLE);
            case (state)
                IDLE: if (accept) begin
                    obs_q          <= obs_i;
                    nsamp_q        <= nsamples_i;
                    seeds_o        <= seed_i;
                    result_valid_o <= 1'b0;
                    busy_o         <= 1'b1;
                    load_seed_o    <= 1'b1;
                    state          <= LOAD_SEED;
                end
                LOAD_SEED: begin
                    line        <= '0;
                    addr_col_o  <= col_of('0);
                    addr_row_o  <= row_of('0);
                    inference_o <= 1'b1;
                    state       <= ADDR;
                end
                ADDR: begin
                    if (line == MatrixSizeLog2'(MatrixSize - 1)) begin
                        if (nsamp_q == '0) begin
                            done_o         <= 1'b1;
                            result_valid_o <= 1'b1;
                            state          <= DONE;
                        end else begin
                            scnt        <= CntWidth'(1);
                            inference_o <= 1'b1;
                            state       <= SAMPLE;
                        end
                    end else begin
                        line        <= nline;
                        addr_col_o  <= col_of(nline);
                        addr_row_o  <= row_of(nline);
                        inference_o <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (scnt == nsamp_q) begin
                        dcnt  <= 2'd1;
                        state <= DRAIN;
                    end else begin
                        scnt        <= scnt + 1'b1;
                        inference_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt == 2'(ArrayLatency)) begin
                        done_o         <= 1'b1;
                        result_valid_o <= 1'b1;
                        state          <= DONE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < MatrixSize; k++) begin : g_lane
        fraise_lane_cnt #(.CntWidth(CntWidth)) u_cnt (
            .clk   (clk_i),
            .reset (reset_i),
            .clear (accept),
            .en    (acc_en && bit_out_i[k]),
            .count (result_o[k*CntWidth +: CntWidth])
        );
    end
endmodule
